// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit.
//   XLEN            data/address width
//   load_funct3_t   RISC-V load funct3 codes
//   store_funct3_t  RISC-V store funct3 codes; the encodings overlap the loads
//   lsu_state_t     control states of the unit
//   req_fault()     misalignment / illegal-funct3 check applied on accept
package load_store_unit_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } store_funct3_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ERR   = 3'd1,
    ST_STORE = 3'd2,
    ST_LOAD  = 3'd3,
    ST_RESP  = 3'd4
  } lsu_state_t;

  // 1 when the request is misaligned or its funct3 is illegal for its direction.
  // Stores only use 000/001/010, so the unsigned load codes fault for stores.
  function automatic logic req_fault(input logic wen, input logic [2:0] funct3,
                                     input logic [1:0] addr_lo);
    logic fault;
    case (funct3)
      3'b000:  fault = 1'b0;
      3'b001:  fault = addr_lo[0];
      3'b010:  fault = (addr_lo != 2'b00);
      3'b100:  fault = wen;
      3'b101:  fault = wen | addr_lo[0];
      default: fault = 1'b1;
    endcase
    return fault;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response bundle between the pipeline and the load/store unit.
//   master: pipeline side (drives req_*, receives req_ready and resp_*)
//   slave : load/store unit side
interface load_store_unit_if
  import load_store_unit_pkg::*;
();

  logic            req_valid;
  logic            req_ready;
  logic            req_wen;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic [XLEN-1:0] resp_data;
  logic            resp_misaligned;

  modport master (
    output req_valid, req_wen, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_data, resp_misaligned
  );

  modport slave (
    input  req_valid, req_wen, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_data, resp_misaligned
  );

endinterface

// File: rtl/load_store_unit_load_ext.sv
// Combinational load-data extender, shared with the writeback stage.
//   funct3   in   load funct3 selecting width and signedness
//   rdata    in   raw data from memory (right-justified)
//   ext_data out  sign/zero-extended result; LW and unknown codes pass through
// Extending data the memory has already extended gives the same value.
module lsu_load_ext
  import load_store_unit_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] ext_data
);

  // Width/sign selection from funct3.
  always_comb begin
    ext_data = rdata;
    case (funct3)
      3'b000:  ext_data = {{(XLEN-8){rdata[7]}}, rdata[7:0]};
      3'b001:  ext_data = {{(XLEN-16){rdata[15]}}, rdata[15:0]};
      3'b100:  ext_data = {{(XLEN-8){1'b0}}, rdata[7:0]};
      3'b101:  ext_data = {{(XLEN-16){1'b0}}, rdata[15:0]};
      default: ext_data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Front end for data port A of the unified memory. Accepts one load/store at
// a time, checks alignment, drives the memory port, waits out the read
// latency and returns extended load data on a one-cycle response strobe.
//   clk, rst    clock, asynchronous active-high reset
//   bus         request/response bundle (slave side)
//   mem_addr    memory addrA
//   mem_sel     memory selA (funct3 passed through)
//   mem_wen     memory wenA, high only during the single store cycle
//   mem_wdata   memory dataA_i (store data, right-justified)
//   mem_rdata   memory dataA_o
// MEM_LAT (1..4) is the memory read latency in cycles.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  load_store_unit_if.slave bus,
  output logic [XLEN-1:0] mem_addr,
  output logic [2:0]      mem_sel,
  output logic            mem_wen,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int CNT_W = 3;

  lsu_state_t      state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]      funct3_r;
  logic            resp_valid_r;
  logic [XLEN-1:0] resp_data_r;
  logic            resp_mis_r;
  logic [XLEN-1:0] ext_s;

  // Ready only in IDLE and forced low while reset is held.
  assign bus.req_ready       = (state_r == ST_IDLE) && !rst;
  assign bus.resp_valid      = resp_valid_r;
  assign bus.resp_data       = resp_data_r;
  assign bus.resp_misaligned = resp_mis_r;

  lsu_load_ext u_ext (
    .funct3   (funct3_r),
    .rdata    (mem_rdata),
    .ext_data (ext_s)
  );

  // Control FSM with registered response and memory-port outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      funct3_r     <= 3'b000;
      resp_valid_r <= 1'b0;
      resp_data_r  <= '0;
      resp_mis_r   <= 1'b0;
      mem_addr     <= '0;
      mem_sel      <= 3'b000;
      mem_wen      <= 1'b0;
      mem_wdata    <= '0;
    end else begin
      // Both strobes last exactly one cycle.
      resp_valid_r <= 1'b0;
      mem_wen      <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.req_valid) begin
            funct3_r <= bus.req_funct3;
            if (req_fault(bus.req_wen, bus.req_funct3, bus.req_addr[1:0])) begin
              // Faulting requests never reach the memory port.
              state_r <= ST_ERR;
            end else begin
              mem_addr <= bus.req_addr;
              mem_sel  <= bus.req_funct3;
              if (bus.req_wen) begin
                mem_wen   <= 1'b1;
                mem_wdata <= bus.req_wdata;
                state_r   <= ST_STORE;
              end else begin
                // LOAD lasts MEM_LAT+1 cycles: counter runs MEM_LAT..0.
                cnt_r   <= CNT_W'(MEM_LAT);
                state_r <= ST_LOAD;
              end
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ERR: begin
          resp_valid_r <= 1'b1;
          resp_data_r  <= '0;
          resp_mis_r   <= 1'b1;
          state_r      <= ST_RESP;
        end
        ST_STORE: begin
          resp_valid_r <= 1'b1;
          resp_data_r  <= '0;
          resp_mis_r   <= 1'b0;
          state_r      <= ST_RESP;
        end
        ST_LOAD: begin
          if (cnt_r == '0) begin
            // Read data is valid at the end of the last LOAD cycle.
            resp_valid_r <= 1'b1;
            resp_data_r  <= ext_s;
            resp_mis_r   <= 1'b0;
            state_r      <= ST_RESP;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        ST_RESP: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: one instance with MEM_LAT=1 and one with MEM_LAT=3,
// each attached to a byte-addressed mock memory with that read latency.
// A transaction-level model predicts per-cycle outputs; directed requests
// additionally carry hand-computed latency/data expectations.
module tb_load_store_unit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   ncyc;

  // Request drive and observed outputs, indexed by instance (0: MEM_LAT=1, 1: MEM_LAT=3).
  logic        rv [2];
  logic        rw [2];
  logic [2:0]  rf [2];
  logic [31:0] ra [2];
  logic [31:0] rd [2];
  logic        rdy [2];
  logic        rvld [2];
  logic [31:0] rdat [2];
  logic        rmis [2];
  logic [31:0] maddr [2];
  logic [2:0]  msel [2];
  logic        mwen [2];
  logic [31:0] mwdata [2];

  logic [31:0] maddr0, maddr1, mwdata0, mwdata1, mrd0, mrd1;
  logic [2:0]  msel0, msel1;
  logic        mwen0, mwen1;

  load_store_unit_if bus0 ();
  load_store_unit_if bus1 ();

  assign bus0.req_valid = rv[0];  assign bus1.req_valid = rv[1];
  assign bus0.req_wen   = rw[0];  assign bus1.req_wen   = rw[1];
  assign bus0.req_funct3 = rf[0]; assign bus1.req_funct3 = rf[1];
  assign bus0.req_addr  = ra[0];  assign bus1.req_addr  = ra[1];
  assign bus0.req_wdata = rd[0];  assign bus1.req_wdata = rd[1];
  assign rdy[0] = bus0.req_ready;  assign rdy[1] = bus1.req_ready;
  assign rvld[0] = bus0.resp_valid; assign rvld[1] = bus1.resp_valid;
  assign rdat[0] = bus0.resp_data;  assign rdat[1] = bus1.resp_data;
  assign rmis[0] = bus0.resp_misaligned; assign rmis[1] = bus1.resp_misaligned;
  assign maddr[0] = maddr0; assign maddr[1] = maddr1;
  assign msel[0] = msel0;   assign msel[1] = msel1;
  assign mwen[0] = mwen0;   assign mwen[1] = mwen1;
  assign mwdata[0] = mwdata0; assign mwdata[1] = mwdata1;

  load_store_unit #(.MEM_LAT(1)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0),
    .mem_addr(maddr0), .mem_sel(msel0), .mem_wen(mwen0),
    .mem_wdata(mwdata0), .mem_rdata(mrd0)
  );

  load_store_unit #(.MEM_LAT(3)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .mem_addr(maddr1), .mem_sel(msel1), .mem_wen(mwen1),
    .mem_wdata(mwdata1), .mem_rdata(mrd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- mock memories ----------------
  // Reads return the addressed byte/half/word right-justified, zero-filled.
  function automatic logic [31:0] pick(input logic [31:0] raw, input logic [2:0] sel);
    case (sel[1:0])
      2'd0:    return {24'h0, raw[7:0]};
      2'd1:    return {16'h0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  logic [7:0]  mem0 [0:255];
  logic [7:0]  mem1 [0:255];
  logic [7:0]  a0, a1;
  logic [31:0] raw0, raw1, p1a, p1b;
  assign a0 = maddr0[7:0];
  assign a1 = maddr1[7:0];
  assign raw0 = {mem0[a0 + 8'd3], mem0[a0 + 8'd2], mem0[a0 + 8'd1], mem0[a0]};
  assign raw1 = {mem1[a1 + 8'd3], mem1[a1 + 8'd2], mem1[a1 + 8'd1], mem1[a1]};

  always_ff @(posedge clk) begin
    if (mwen0) begin
      for (int i = 0; i < 4; i++)
        if (i < (1 << msel0[1:0])) mem0[a0 + 8'(i)] <= mwdata0[8*i +: 8];
    end
    mrd0 <= pick(raw0, msel0);
  end

  always_ff @(posedge clk) begin
    if (mwen1) begin
      for (int i = 0; i < 4; i++)
        if (i < (1 << msel1[1:0])) mem1[a1 + 8'(i)] <= mwdata1[8*i +: 8];
    end
    p1a  <= pick(raw1, msel1);
    p1b  <= p1a;
    mrd1 <= p1b;
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d cycle %0d: actual %h required %h", name, d, ncyc, act, exp);
    end
  endtask

  // Architectural result of a load: funct3 chooses width and signedness.
  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] raw);
    case (f3)
      3'b000:  return int'($signed(raw[7:0]));
      3'b001:  return int'($signed(raw[15:0]));
      3'b100:  return 32'(raw[7:0]);
      3'b101:  return 32'(raw[15:0]);
      default: return raw;
    endcase
  endfunction

  // Transaction model state: one outstanding request per instance.
  logic [7:0]  refm [2][256];
  bit          busy [2];
  int          due [2];
  int          wen_cyc [2];
  logic [31:0] e_data [2];
  logic        e_mis [2];
  logic [31:0] e_addr [2];
  logic [31:0] e_wdata [2];
  logic [2:0]  e_f3 [2];
  int          e_size [2];

  // Per-cycle prediction and comparison, sampled on the falling edge.
  always @(negedge clk) begin
    ncyc++;
    for (int d = 0; d < 2; d++) begin
      bit          diff;
      bit          erdy, erv, ewen, legal;
      logic [31:0] raw;
      int          size, lat;
      lat  = (d == 0) ? 1 : 3;
      diff = 1'b0;
      for (int a = 0; a < 256; a++)
        if (((d == 0) ? mem0[a] : mem1[a]) !== refm[d][a]) diff = 1'b1;
      check("memory_contents", d, 32'(diff), 32'd0);
      if (rst) begin
        check("rst_req_ready", d, 32'(rdy[d]), 32'd0);
        check("rst_resp_valid", d, 32'(rvld[d]), 32'd0);
        check("rst_resp_data", d, rdat[d], 32'd0);
        check("rst_resp_mis", d, 32'(rmis[d]), 32'd0);
        check("rst_mem_wen", d, 32'(mwen[d]), 32'd0);
        check("rst_mem_addr", d, maddr[d], 32'd0);
        check("rst_mem_sel", d, 32'(msel[d]), 32'd0);
        check("rst_mem_wdata", d, mwdata[d], 32'd0);
        busy[d] = 1'b0;
      end else begin
        erdy = !busy[d];
        erv  = busy[d] && (ncyc == due[d]);
        ewen = busy[d] && (ncyc == wen_cyc[d]);
        check("req_ready", d, 32'(rdy[d]), 32'(erdy));
        check("resp_valid", d, 32'(rvld[d]), 32'(erv));
        check("mem_wen", d, 32'(mwen[d]), 32'(ewen));
        if (erv) begin
          check("resp_data", d, rdat[d], e_data[d]);
          check("resp_misaligned", d, 32'(rmis[d]), 32'(e_mis[d]));
          busy[d] = 1'b0;
        end
        if (busy[d] && !e_mis[d] && (ncyc < due[d])) begin
          check("mem_addr", d, maddr[d], e_addr[d]);
          check("mem_sel", d, 32'(msel[d]), 32'(e_f3[d]));
        end
        if (ewen) begin
          check("mem_wdata", d, mwdata[d], e_wdata[d]);
          for (int i = 0; i < e_size[d]; i++)
            refm[d][8'(e_addr[d] + 32'(i))] = e_wdata[d][8*i +: 8];
        end
        if (erdy && rv[d] === 1'b1) begin
          legal = rw[d] ? (rf[d] <= 3'd2) : (rf[d] inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
          size  = 1 << rf[d][1:0];
          busy[d]    = 1'b1;
          wen_cyc[d] = -1;
          e_addr[d]  = ra[d];
          e_f3[d]    = rf[d];
          e_wdata[d] = rd[d];
          e_size[d]  = size;
          e_data[d]  = 32'd0;
          e_mis[d]   = !legal || ((int'(ra[d][1:0]) % size) != 0);
          if (e_mis[d]) begin
            due[d] = ncyc + 2;
          end else if (rw[d]) begin
            wen_cyc[d] = ncyc + 1;
            due[d]     = ncyc + 2;
          end else begin
            for (int i = 0; i < 4; i++) raw[8*i +: 8] = refm[d][8'(ra[d] + 32'(i))];
            e_data[d] = load_value(rf[d], raw);
            due[d]    = ncyc + lat + 2;
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  // Waits (bounded) for acceptance of the request on rv[d]; returns in cycle 1.
  task automatic wait_accept(input int d, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rdy[d] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("accept_timeout", d, 32'd1, 32'd0);
      rv[d] = 1'b0;
    end else begin
      @(posedge clk);
      #1 rv[d] = 1'b0;
    end
  endtask

  task automatic do_req(input int d, input bit wen, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int exp_lat, input logic [31:0] exp_data, input bit exp_mis);
    bit ok;
    int lat;
    @(posedge clk);
    #1;
    rw[d] = wen; rf[d] = f3; ra[d] = addr; rd[d] = wdata; rv[d] = 1'b1;
    wait_accept(d, ok);
    if (ok) begin
      lat = -1;
      for (int c = 1; c <= 12; c++) begin
        @(negedge clk);
        if (rvld[d] === 1'b1) begin
          lat = c;
          break;
        end
      end
      check("pin_latency", d, 32'(lat), 32'(exp_lat));
      if (lat > 0) begin
        check("pin_data", d, rdat[d], exp_data);
        check("pin_misaligned", d, 32'(rmis[d]), 32'(exp_mis));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int acc [3];
    bit ok;
    n_checks = 0;
    n_errors = 0;
    ncyc = 0;
    for (int d = 0; d < 2; d++) begin
      rv[d] = 1'b0; rw[d] = 1'b0; rf[d] = 3'd0; ra[d] = 32'd0; rd[d] = 32'd0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Store then load back, then each extension flavour.
    do_req(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 2, 32'h0, 1'b0);
    do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0);
    do_req(0, 1'b0, 3'b000, 32'h13, 32'h0, 3, 32'hFFFFFFDE, 1'b0);
    do_req(0, 1'b0, 3'b100, 32'h13, 32'h0, 3, 32'h000000DE, 1'b0);
    do_req(0, 1'b0, 3'b001, 32'h12, 32'h0, 3, 32'hFFFFDEAD, 1'b0);
    do_req(0, 1'b0, 3'b101, 32'h10, 32'h0, 3, 32'h0000BEEF, 1'b0);

    // Faults: misaligned LW/SH, illegal load and store funct3.
    do_req(0, 1'b0, 3'b010, 32'h11, 32'h0, 2, 32'h0, 1'b1);
    do_req(0, 1'b1, 3'b001, 32'h13, 32'h12345678, 2, 32'h0, 1'b1);
    do_req(0, 1'b0, 3'b011, 32'h20, 32'h0, 2, 32'h0, 1'b1);
    do_req(0, 1'b1, 3'b100, 32'h30, 32'hFFFFFFFF, 2, 32'h0, 1'b1);
    do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0);

    // Three stores with req_valid held high: accepts must be 3 cycles apart.
    @(posedge clk);
    #1;
    rw[0] = 1'b1; rf[0] = 3'b010; ra[0] = 32'h20; rd[0] = 32'h11111111; rv[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ok = 1'b0;
      acc[i] = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (rdy[0] === 1'b1) begin
          ok = 1'b1;
          acc[i] = ncyc;
          break;
        end
      end
      @(posedge clk);
      #1;
      if (i == 0) begin ra[0] = 32'h24; rd[0] = 32'h22222222; end
      else if (i == 1) begin ra[0] = 32'h28; rd[0] = 32'h33333333; end
      else rv[0] = 1'b0;
    end
    check("b2b_spacing_1", 0, 32'(acc[1] - acc[0]), 32'd3);
    check("b2b_spacing_2", 0, 32'(acc[2] - acc[1]), 32'd3);
    do_req(0, 1'b0, 3'b010, 32'h20, 32'h0, 3, 32'h11111111, 1'b0);
    do_req(0, 1'b0, 3'b010, 32'h24, 32'h0, 3, 32'h22222222, 1'b0);
    do_req(0, 1'b0, 3'b010, 32'h28, 32'h0, 3, 32'h33333333, 1'b0);

    // Sub-word stores ignore the upper bits of the store data.
    do_req(0, 1'b1, 3'b000, 32'h21, 32'hFFFFFFAB, 2, 32'h0, 1'b0);
    do_req(0, 1'b0, 3'b010, 32'h20, 32'h0, 3, 32'h1111AB11, 1'b0);
    do_req(0, 1'b1, 3'b001, 32'h26, 32'h1234CAFE, 2, 32'h0, 1'b0);
    do_req(0, 1'b0, 3'b010, 32'h24, 32'h0, 3, 32'hCAFE2222, 1'b0);
    do_req(0, 1'b0, 3'b001, 32'h26, 32'h0, 3, 32'hFFFFCAFE, 1'b0);

    // Reset during the store cycle aborts the write.
    @(posedge clk);
    #1;
    rw[0] = 1'b1; rf[0] = 3'b010; ra[0] = 32'h10; rd[0] = 32'h55555555; rv[0] = 1'b1;
    wait_accept(0, ok);
    if (ok) begin
      check("abort_wen_before_rst", 0, 32'(mwen[0]), 32'd1);
      #1 rst = 1'b1;
      #1 check("abort_wen_async_drop", 0, 32'(mwen[0]), 32'd0);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("ready_after_release", 0, 32'(rdy[0]), 32'd1);
    end
    do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0);

    // Three-cycle memory latency.
    do_req(1, 1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 2, 32'h0, 1'b0);
    do_req(1, 1'b0, 3'b010, 32'h40, 32'h0, 5, 32'hCAFEF00D, 1'b0);
    do_req(1, 1'b0, 3'b001, 32'h42, 32'h0, 5, 32'hFFFFCAFE, 1'b0);
    do_req(1, 1'b0, 3'b100, 32'h41, 32'h0, 5, 32'h000000F0, 1'b0);
    do_req(1, 1'b0, 3'b000, 32'h41, 32'h0, 5, 32'hFFFFFFF0, 1'b0);
    do_req(1, 1'b0, 3'b101, 32'h43, 32'h0, 2, 32'h0, 1'b1);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
